// File: rtl/nibble_serial_addsub_ctrl.sv
// Multi-word add/subtract sequencer driving one shared 4-bit combinational adder,
// one nibble per clock, LSB nibble first, with carry chaining and result assembly.
module nibble_serial_addsub_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   op_sub,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   carry_out,
    output logic                   overflow,
    output logic [3:0]             add_bin1,
    output logic [3:0]             add_bin2,
    output logic                   add_cin,
    input  logic [3:0]             add_sum,
    input  logic                   add_carry
);
    localparam int WIDTH = 4 * NIBBLES;
    localparam int IDXW  = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [IDXW-1:0]   idx_q;
    logic [WIDTH-1:0]  a_q, bp_q, result_q;
    logic              carry_q, carry_out_q, overflow_q;
    logic              last;

    assign last = (idx_q == IDXW'(NIBBLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last)  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The adder XORs bin2 with cin internally, so bin2 is pre-XORed with the
    // chained carry to make it compute a + b' + cin for every nibble.
    always_comb begin
        add_bin1 = 4'h0;
        add_bin2 = 4'h0;
        add_cin  = 1'b0;
        if (state_q == RUN) begin
            add_bin1 = a_q[{idx_q, 2'b00} +: 4];
            add_bin2 = bp_q[{idx_q, 2'b00} +: 4] ^ {4{carry_q}};
            add_cin  = carry_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q       <= '0;
            a_q         <= '0;
            bp_q        <= '0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    a_q     <= a;
                    bp_q    <= op_sub ? ~b : b;
                    carry_q <= op_sub;
                    idx_q   <= '0;
                end
                RUN: begin
                    result_q[{idx_q, 2'b00} +: 4] <= add_sum;
                    carry_q <= add_carry;
                    idx_q   <= idx_q + IDXW'(1);
                    if (last) begin
                        carry_out_q <= add_carry;
                        overflow_q  <= (a_q[WIDTH-1] == bp_q[WIDTH-1]) &&
                                       (add_sum[3] != a_q[WIDTH-1]);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;
endmodule

// File: tb/tb_nibble_serial_addsub_ctrl.sv
// Directed bench: vector table of wide add/sub operations plus hand-written
// sequences for start-ignore, mid-RUN reset and back-to-back starts.
module tb_nibble_serial_addsub_ctrl;
    localparam int NIB = 4;

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, op_sub = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic        busy, done, carry_out, overflow, add_cin, add_carry;
    logic [15:0] result;
    logic [3:0]  add_bin1, add_bin2, add_sum;
    logic [4:0]  adder_full;

    int n_vec = 0, n_err = 0;

    always #5 clk = ~clk;

    // External 4-bit adder/subtractor: bin2 is XORed with cin internally.
    assign adder_full = {1'b0, add_bin1} + {1'b0, add_bin2 ^ {4{add_cin}}} + {4'b0, add_cin};
    assign add_sum    = adder_full[3:0];
    assign add_carry  = adder_full[4];

    nibble_serial_addsub_ctrl #(.NIBBLES(NIB)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op_sub(op_sub), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .carry_out(carry_out),
        .overflow(overflow), .add_bin1(add_bin1), .add_bin2(add_bin2),
        .add_cin(add_cin), .add_sum(add_sum), .add_carry(add_carry)
    );

    typedef struct {
        logic [15:0] a, b;
        logic        sub;
        logic [15:0] res;
        logic        cout, ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after an edge with the DUT idle; returns after the done cycle.
    task automatic run_op(input string nm, input logic [15:0] va, input logic [15:0] vb,
                          input logic vs, input logic [15:0] eres, input logic ecout,
                          input logic eovf);
        int bc;
        a = va; b = vb; op_sub = vs; start = 1'b1;
        tick();
        start = 1'b0;
        bc = 0;
        while (busy && bc < 20) begin
            bc++;
            tick();
        end
        check({nm, " busy_cycles"}, bc, NIB);
        check({nm, " done"}, done, 1'b1);
        check({nm, " result"}, result, eres);
        check({nm, " carry_out"}, carry_out, ecout);
        check({nm, " overflow"}, overflow, eovf);
        tick();
        check({nm, " done_width"}, done, 1'b0);
    endtask

    initial begin
        int cyc, ndone, last_done, bad_gap, bad_idle;
        vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0};
        vecs[1] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[4] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[5] = '{16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0};
        vecs[6] = '{16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[7] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};

        #12;
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst result", result, 0);
        check("rst flags", {carry_out, overflow}, 0);
        check("rst adder", {add_bin1, add_bin2, add_cin}, 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++)
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sub,
                   vecs[i].res, vecs[i].cout, vecs[i].ovf);

        // First RUN cycle of a subtract: carry-in 1, bin2 pre-compensated.
        a = 16'h0005; b = 16'h0007; op_sub = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        check("sub run0 bin1", add_bin1, 4'h5);
        check("sub run0 cin", add_cin, 1'b1);
        check("sub run0 bin2", add_bin2, 4'h7);
        repeat (NIB + 1) tick();
        check("sub result", result, 16'hFFFE);

        // Start pulsed again during RUN with different operands is ignored.
        a = 16'h8000; b = 16'h0001; op_sub = 1'b1; start = 1'b1;
        tick();
        a = 16'h1111; b = 16'h2222; op_sub = 1'b0;
        tick();
        start = 1'b0;
        repeat (NIB - 1) tick();
        check("ign done", done, 1'b1);
        check("ign result", result, 16'h7FFF);
        check("ign flags", {carry_out, overflow}, 2'b11);
        tick();
        check("ign no restart", busy, 1'b0);

        // Reset in the second RUN cycle aborts everything.
        a = 16'hABCD; b = 16'h1111; op_sub = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check("abort busy", busy, 0);
        check("abort result", result, 0);
        check("abort flags", {done, carry_out, overflow}, 0);
        check("abort adder", {add_bin1, add_bin2, add_cin}, 0);
        #2 rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done) ndone++;
        end
        check("abort no done", ndone, 0);
        run_op("post_rst", 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0);

        // Start held high: one acceptance every NIB+2 cycles.
        a = 16'h0001; b = 16'h0001; op_sub = 1'b0; start = 1'b1;
        ndone = 0; last_done = -1; bad_gap = 0; bad_idle = 0;
        for (cyc = 1; cyc <= 18; cyc++) begin
            tick();
            if (!busy && ({add_bin1, add_bin2, add_cin} != 9'd0)) bad_idle++;
            if (done) begin
                if (last_done >= 0 && cyc - last_done != NIB + 2) bad_gap++;
                if (last_done < 0 && cyc != NIB + 1) bad_gap++;
                last_done = cyc;
                ndone++;
            end
        end
        start = 1'b0;
        check("b2b done count", ndone, 3);
        check("b2b spacing", bad_gap, 0);
        check("b2b idle adder", bad_idle, 0);
        check("b2b result", result, 16'h0002);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
